// File: rtl/fc_layer_engine.sv
// Folded fully-connected layer: LANES shared MAC lanes time-multiplexed over
// NEURON_NUM neurons, with internal weight/bias memories and a streamed result port.
module fc_layer_engine #(
   parameter int unsigned NEURON_NUM = 30,
   parameter int unsigned WEIGHT_NUM = 784,
   parameter int unsigned LANES      = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned INT_WIDTH  = 4,
   parameter int unsigned LAYER_NO   = 1,
   parameter string       ACT_TYPE   = "relu"
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           weight_value,
   input  logic                  weight_valid,
   input  logic [31:0]           bias_value,
   input  logic                  bias_valid,
   input  logic [31:0]           config_layer_num,
   input  logic [31:0]           config_neuron_num,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [(NEURON_NUM > 1 ? $clog2(NEURON_NUM) : 1)-1:0] out_index,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready
);

   localparam int unsigned DW     = DATA_WIDTH;
   localparam int unsigned FRAC   = DATA_WIDTH - INT_WIDTH;
   localparam int unsigned IDX_W  = NEURON_NUM > 1 ? $clog2(NEURON_NUM) : 1;
   localparam int unsigned XW     = WEIGHT_NUM > 1 ? $clog2(WEIGHT_NUM) : 1;
   localparam int unsigned KW     = $clog2(WEIGHT_NUM + 2);
   localparam int unsigned GROUPS = (NEURON_NUM + LANES - 1) / LANES;
   localparam int unsigned GW     = GROUPS > 1 ? $clog2(GROUPS) : 1;
   localparam int unsigned LW     = LANES > 1 ? $clog2(LANES) : 1;
   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(WEIGHT_NUM);
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam bit          RELU   = (ACT_TYPE == "relu");
   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

   state_t                  state, state_nx;
   logic [XW-1:0]           icnt, wptr, wptr_eff;
   logic [KW-1:0]           kcnt;
   logic [GW-1:0]           g;
   logic [LW-1:0]           olane;
   logic                    rd_valid;
   logic [31:0]             cfg_layer_q, cfg_neuron_q;
   logic                    cfg_hit, cfg_chg, in_beat, finalize, out_xfer, more, last_group;

   logic signed [DW-1:0]    x_buf [WEIGHT_NUM];
   logic signed [DW-1:0]    w_mem [NEURON_NUM][WEIGHT_NUM];
   logic signed [DW-1:0]    b_mem [NEURON_NUM];
   logic signed [DW-1:0]    x_q;
   logic signed [DW-1:0]    w_q    [LANES];
   logic signed [ACC_W-1:0] acc    [LANES];
   logic signed [DW-1:0]    res    [LANES];
   logic signed [PROD_W-1:0] prod  [LANES];
   logic signed [DW-1:0]    bias_l [LANES];
   logic signed [SUM_W-1:0] sum_l  [LANES];
   logic signed [SUM_W-1:0] sh_l   [LANES];
   logic signed [DW-1:0]    fin    [LANES];
   logic [31:0]             lane_n [LANES];
   logic [LANES-1:0]        lane_on;
   logic                    unused_cfg;

   assign unused_cfg = ^{weight_value[31:DW], bias_value[31:DW]};

   assign cfg_hit    = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num < 32'(NEURON_NUM));
   assign cfg_chg    = (config_layer_num != cfg_layer_q) || (config_neuron_num != cfg_neuron_q);
   assign wptr_eff   = cfg_chg ? '0 : wptr;
   assign in_beat    = (state == S_LOAD) && in_valid && in_ready;
   assign finalize   = (state == S_COMPUTE) && (kcnt == KW'(WEIGHT_NUM + 1));
   assign out_xfer   = (state == S_OUTPUT) && out_valid && out_ready;
   assign more       = (olane != LW'(LANES - 1)) && (out_index != IDX_W'(NEURON_NUM - 1));
   assign last_group = (g == GW'(GROUPS - 1));

   // Memories and input buffer carry no reset
   always_ff @(posedge clk) begin
      if (in_beat) x_buf[icnt] <= in_data;
      if (weight_valid && cfg_hit) w_mem[IDX_W'(config_neuron_num)][wptr_eff] <= weight_value[DW-1:0];
      if (bias_valid && cfg_hit)   b_mem[IDX_W'(config_neuron_num)] <= bias_value[DW-1:0];
   end

   // Write pointer restarts whenever the config target changes
   always_ff @(posedge clk) begin
      cfg_layer_q  <= config_layer_num;
      cfg_neuron_q <= config_neuron_num;
      if (rst)                          wptr <= '0;
      else if (weight_valid && cfg_hit) wptr <= (wptr_eff == XW'(WEIGHT_NUM - 1)) ? '0 : wptr_eff + 1'b1;
      else                              wptr <= wptr_eff;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_LOAD:    if (in_beat && icnt == XW'(WEIGHT_NUM - 1)) state_nx = S_COMPUTE;
         S_COMPUTE: if (finalize) state_nx = S_OUTPUT;
         S_OUTPUT:  if (out_xfer && !more) state_nx = last_group ? S_LOAD : S_COMPUTE;
         default:   state_nx = S_LOAD;
      endcase
   end

   // Per-lane neuron mapping, products and bias/shift/saturate/activate
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_n[l]  = 32'(g) * LANES + 32'(l);
         lane_on[l] = lane_n[l] < 32'(NEURON_NUM);
         prod[l]    = PROD_W'(x_q) * PROD_W'(w_q[l]);
         bias_l[l]  = lane_on[l] ? b_mem[IDX_W'(lane_n[l])] : '0;
         sum_l[l]   = SUM_W'(acc[l]) + (SUM_W'(bias_l[l]) <<< FRAC);
         sh_l[l]    = sum_l[l] >>> FRAC;
         if (sh_l[l] > SAT_MAX)      fin[l] = DW'(SAT_MAX);
         else if (sh_l[l] < SAT_MIN) fin[l] = DW'(SAT_MIN);
         else                        fin[l] = DW'(sh_l[l]);
         if (RELU && fin[l][DW-1])   fin[l] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b0;
         icnt      <= '0;
         g         <= '0;
         kcnt      <= '0;
         olane     <= '0;
         rd_valid  <= 1'b0;
         x_q       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         for (int l = 0; l < LANES; l++) begin
            w_q[l] <= '0;
            acc[l] <= '0;
            res[l] <= '0;
         end
      end else begin
         in_ready <= (state_nx == S_LOAD);
         if (in_beat) icnt <= (state_nx == S_COMPUTE) ? '0 : icnt + 1'b1;
         if (state == S_LOAD)          g <= '0;
         else if (out_xfer && !more)   g <= g + 1'b1;
         kcnt     <= (state == S_COMPUTE && !finalize) ? kcnt + 1'b1 : '0;
         rd_valid <= (state == S_COMPUTE) && (kcnt < KW'(WEIGHT_NUM));
         // Registered read of x and one weight per lane; accumulate a cycle later
         if (state == S_COMPUTE && kcnt < KW'(WEIGHT_NUM)) begin
            x_q <= x_buf[XW'(kcnt)];
            for (int l = 0; l < LANES; l++)
               w_q[l] <= lane_on[l] ? w_mem[IDX_W'(lane_n[l])][XW'(kcnt)] : '0;
         end
         for (int l = 0; l < LANES; l++) begin
            if (state == S_COMPUTE && kcnt == '0) acc[l] <= '0;
            else if (rd_valid)                    acc[l] <= acc[l] + ACC_W'(prod[l]);
         end
         if (finalize) begin
            for (int l = 0; l < LANES; l++) res[l] <= fin[l];
            out_valid <= 1'b1;
            out_data  <= fin[0];
            out_index <= IDX_W'(lane_n[0]);
            out_last  <= (lane_n[0] == 32'(NEURON_NUM - 1));
            olane     <= '0;
         end else if (out_xfer) begin
            if (more) begin
               olane     <= olane + 1'b1;
               out_data  <= res[olane + 1'b1];
               out_index <= out_index + 1'b1;
               out_last  <= (out_index + 1'b1 == IDX_W'(NEURON_NUM - 1));
            end else begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         end
      end
   end

endmodule
